uart_rx_fifo_ctrl: RTL and testbench



---
 rtl/uart_rx_fifo_ctrl_pkg.sv | 22 ++
 rtl/uart_rx_fifo_ctrl_sync_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// uart_pkg: shared constants for the UART RX FIFO controller.
//   - register select values for the two-register bus window
//   - CTRL / DATA bit positions
//   - capture FSM state encoding
package uart_pkg;

   localparam logic SEL_DATA = 1'b0;
   localparam logic SEL_CTRL = 1'b1;

   localparam int CTRL_THR_LSB = 8;
   localparam int CTRL_IRQ_EN  = 16;
   localparam int CTRL_FLUSH   = 17;
   localparam int CTRL_OVF_CLR = 18;

   localparam int DATA_NONEMPTY = 31;
   localparam int DATA_OVF      = 30;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACK  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

endpackage

// File: rtl/uart_rx_fifo_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write request and data (accepted when not full, or when a
//                pop is accepted in the same cycle)
//   pop        : read request (ignored when empty)
//   flush      : empties the FIFO; overrides push and pop
//   dout       : entry at the head (undefined content when empty)
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q;
   logic             push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem_q[head_q];
   assign count   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) tail_q <= tail_q + AW'(1);
         if (pop_ok)  head_q <= head_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[tail_q] <= din;
   end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: captures bytes from a UART receiver into a FIFO and
// exposes them through a two-register bus window.
//   clk, rst_n        : clock, async active-low reset
//   rx_dv, rx_byte    : receiver byte valid (held until acknowledged) / data
//   rx_next           : one-cycle acknowledge back to the receiver
//   mem_sel           : 0 = DATA, 1 = CTRL
//   mem_wen, mem_wdata: one-cycle write strobe and data
//   mem_rdata         : combinational read data for the selected register
//   irq               : registered threshold interrupt
module uart_rx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   output logic        rx_next,
   input  logic        mem_sel,
   input  logic        mem_wen,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        irq
);

   localparam int COUNT_W = ADDR_W + 1;

   logic [1:0]         state_q, state_d;
   logic               ovf_q, ovf_d;
   logic               irq_en_q, irq_en_d;
   logic [COUNT_W-1:0] thr_q, thr_d;
   logic               irq_q, irq_d;

   logic               push, pop, pop_ok, flush, ovf_clr, ovf_set, ctrl_wr;
   logic [7:0]         dout;
   logic [COUNT_W-1:0] count;
   logic               full, empty;
   logic               unused_wdata;

   assign unused_wdata = ^mem_wdata;

   // Capture FSM: push once on entry, acknowledge, then wait for the
   // receiver to drop rx_dv so a held byte is never captured twice.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: if (rx_dv) begin
            push    = 1'b1;
            state_d = S_ACK;
         end
         S_ACK:  state_d = S_WAIT;
         S_WAIT: if (!rx_dv) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_next = (state_q == S_ACK);

   assign ctrl_wr = mem_wen && (mem_sel == SEL_CTRL);
   assign pop     = mem_wen && (mem_sel == SEL_DATA) && mem_wdata[DATA_NONEMPTY];
   assign flush   = ctrl_wr && mem_wdata[CTRL_FLUSH];
   assign ovf_clr = ctrl_wr && mem_wdata[CTRL_OVF_CLR];
   assign pop_ok  = pop && !empty;
   // A byte discarded by a flush is not an overflow.
   assign ovf_set = push && full && !pop_ok && !flush;

   assign ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   assign thr_d    = ctrl_wr ? mem_wdata[CTRL_THR_LSB +: COUNT_W] : thr_q;
   assign irq_en_d = ctrl_wr ? mem_wdata[CTRL_IRQ_EN] : irq_en_q;
   // Uses the pre-update count, so irq trails count changes by one cycle.
   assign irq_d    = irq_en_q && (thr_q != '0) && (count >= thr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         thr_q    <= COUNT_W'(1);
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         thr_q    <= thr_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (rx_byte),
      .dout  (dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      mem_rdata = '0;
      if (mem_sel == SEL_DATA) begin
         mem_rdata[DATA_NONEMPTY] = !empty;
         mem_rdata[DATA_OVF]      = ovf_q;
         mem_rdata[7:0]           = empty ? 8'h00 : dout;
      end else begin
         mem_rdata[COUNT_W-1:0]              = count;
         mem_rdata[CTRL_THR_LSB +: COUNT_W]  = thr_q;
         mem_rdata[CTRL_IRQ_EN]              = irq_en_q;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
module tb_uart_rx_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, rx_dv, rx_next, mem_sel, mem_wen, irq;
   logic [7:0]  rx_byte;
   logic [31:0] mem_wdata, mem_rdata;
   logic [31:0] d;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .rx_next(rx_next), .mem_sel(mem_sel), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .irq(irq)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic sel, output logic [31:0] v);
      mem_sel = sel; #1; v = mem_rdata;
   endtask

   task automatic wr(input logic sel, input logic [31:0] v);
      mem_sel = sel; mem_wdata = v; mem_wen = 1'b1;
      tick();
      mem_wen = 1'b0; mem_wdata = '0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_dv = 1'b1; rx_byte = b;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rx_next) break;
      end
      checks++; if (rx_next !== 1'b1) begin failures++; $display("FAIL push_ack_timeout got=%b exp=1", rx_next); end
      rx_dv = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0; mem_sel = 1'b0; mem_wen = 1'b0; mem_wdata = '0;
      repeat (3) tick();
      @(negedge clk); rst_n = 1'b1;
      tick();
      rd(1'b0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", d, 32'h0); end
      rd(1'b1, d); checks++; if (d !== 32'h100) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h100); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (rx_next !== 1'b0) begin failures++; $display("FAIL reset_rx_next got=%b exp=0", rx_next); end
   endtask

   task automatic test_single();
      int pulses = 0;
      rx_dv = 1'b1; rx_byte = 8'h41;
      checks++; if (rx_next !== 1'b0) begin failures++; $display("FAIL single_pre_ack got=%b exp=0", rx_next); end
      tick();
      checks++; if (rx_next !== 1'b1) begin failures++; $display("FAIL single_ack got=%b exp=1", rx_next); end
      rd(1'b0, d); checks++; if (d !== 32'h80000041) begin failures++; $display("FAIL single_data got=%h exp=%h", d, 32'h80000041); end
      rd(1'b1, d); checks++; if (d !== 32'h101) begin failures++; $display("FAIL single_count got=%h exp=%h", d, 32'h101); end
      repeat (5) begin tick(); if (rx_next) pulses++; end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL single_extra_ack got=%0d exp=0", pulses); end
      rd(1'b1, d); checks++; if (d !== 32'h101) begin failures++; $display("FAIL single_no_repush got=%h exp=%h", d, 32'h101); end
      rx_dv = 1'b0; tick();
      wr(1'b0, 32'h80000000);
      rd(1'b0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL single_pop_empty got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      rd(1'b1, d); checks++; if (d !== 32'h110) begin failures++; $display("FAIL ovf_full_count got=%h exp=%h", d, 32'h110); end
      push_byte(8'hAA);
      rd(1'b0, d); checks++; if (d !== 32'hC0000000) begin failures++; $display("FAIL ovf_flag got=%h exp=%h", d, 32'hC0000000); end
      rd(1'b1, d); checks++; if (d !== 32'h110) begin failures++; $display("FAIL ovf_count got=%h exp=%h", d, 32'h110); end
      for (int i = 0; i < 16; i++) begin
         rd(1'b0, d);
         checks++; if (d !== (32'hC0000000 | 32'(i))) begin failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, d, 32'hC0000000 | 32'(i)); end
         wr(1'b0, 32'h80000000);
      end
      rd(1'b0, d); checks++; if (d !== 32'h40000000) begin failures++; $display("FAIL ovf_drained got=%h exp=%h", d, 32'h40000000); end
      wr(1'b1, 32'h00040100);
      rd(1'b0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
      rx_dv = 1'b1; rx_byte = 8'h55;
      wr(1'b0, 32'h80000000);
      checks++; if (rx_next !== 1'b1) begin failures++; $display("FAIL fullpp_ack got=%b exp=1", rx_next); end
      rd(1'b1, d); checks++; if (d !== 32'h110) begin failures++; $display("FAIL fullpp_count got=%h exp=%h", d, 32'h110); end
      rd(1'b0, d); checks++; if (d !== 32'h80000011) begin failures++; $display("FAIL fullpp_head got=%h exp=%h", d, 32'h80000011); end
      rx_dv = 1'b0; tick(); tick();
      for (int i = 0; i < 16; i++) begin
         exp = (i < 15) ? (32'h80000011 + 32'(i)) : 32'h80000055;
         rd(1'b0, d);
         checks++; if (d !== exp) begin failures++; $display("FAIL fullpp_pop%0d got=%h exp=%h", i, d, exp); end
         wr(1'b0, 32'h80000000);
      end
      rd(1'b0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL fullpp_empty got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_back_to_back();
      rx_dv = 1'b1; rx_byte = 8'h66;
      wr(1'b0, 32'h80000000);
      rd(1'b1, d); checks++; if (d !== 32'h101) begin failures++; $display("FAIL b2b_empty_count got=%h exp=%h", d, 32'h101); end
      rd(1'b0, d); checks++; if (d !== 32'h80000066) begin failures++; $display("FAIL b2b_empty_data got=%h exp=%h", d, 32'h80000066); end
      rx_dv = 1'b0; tick(); tick();
      rx_dv = 1'b1; rx_byte = 8'h77;
      wr(1'b0, 32'h80000000);
      rd(1'b1, d); checks++; if (d !== 32'h101) begin failures++; $display("FAIL b2b_one_count got=%h exp=%h", d, 32'h101); end
      rd(1'b0, d); checks++; if (d !== 32'h80000077) begin failures++; $display("FAIL b2b_one_data got=%h exp=%h", d, 32'h80000077); end
      rx_dv = 1'b0; tick(); tick();
      wr(1'b0, 32'h80000000);
   endtask

   task automatic test_irq();
      wr(1'b1, 32'h00010300);
      push_byte(8'h01); push_byte(8'h02);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", irq); end
      rx_dv = 1'b1; rx_byte = 8'h03;
      tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_same_cycle got=%b exp=0", irq); end
      rx_dv = 1'b0; tick();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
      tick();
      wr(1'b0, 32'h80000000);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq); end
      tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
      wr(1'b1, 32'h00010000); tick(); tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_thr0 got=%b exp=0", irq); end
      wr(1'b1, 32'h00011100); tick(); tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_thr17 got=%b exp=0", irq); end
      wr(1'b1, 32'h00020100);
      rd(1'b1, d); checks++; if (d !== 32'h100) begin failures++; $display("FAIL irq_restore got=%h exp=%h", d, 32'h100); end
   endtask

   task automatic test_flush_reset();
      for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
      rd(1'b1, d); checks++; if (d !== 32'h105) begin failures++; $display("FAIL flush_pre_count got=%h exp=%h", d, 32'h105); end
      rx_dv = 1'b1; rx_byte = 8'h99;
      wr(1'b1, 32'h00020200);
      checks++; if (rx_next !== 1'b1) begin failures++; $display("FAIL flush_ack got=%b exp=1", rx_next); end
      rd(1'b1, d); checks++; if (d !== 32'h200) begin failures++; $display("FAIL flush_ctrl got=%h exp=%h", d, 32'h200); end
      rd(1'b0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL flush_data got=%h exp=%h", d, 32'h0); end
      tick();
      checks++; if (rx_next !== 1'b0) begin failures++; $display("FAIL flush_wait_ack got=%b exp=0", rx_next); end
      rd(1'b1, d); checks++; if (d !== 32'h200) begin failures++; $display("FAIL flush_wait_count got=%h exp=%h", d, 32'h200); end
      rst_n = 1'b0; #1;
      checks++; if (rx_next !== 1'b0) begin failures++; $display("FAIL rst_wait_ack got=%b exp=0", rx_next); end
      rd(1'b1, d); checks++; if (d !== 32'h100) begin failures++; $display("FAIL rst_wait_ctrl got=%h exp=%h", d, 32'h100); end
      rx_byte = 8'h5A;
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++; if (rx_next !== 1'b1) begin failures++; $display("FAIL rst_recapture_ack got=%b exp=1", rx_next); end
      rd(1'b0, d); checks++; if (d !== 32'h8000005A) begin failures++; $display("FAIL rst_recapture_data got=%h exp=%h", d, 32'h8000005A); end
      rst_n = 1'b0; #1;
      checks++; if (rx_next !== 1'b0) begin failures++; $display("FAIL rst_ack_drop got=%b exp=0", rx_next); end
      rd(1'b0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_ack_data got=%h exp=%h", d, 32'h0); end
      rx_dv = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_irq();
      test_flush_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
